// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU-pin bundle for the ALU operation sequencer.
// The slave side is the sequencer; the master side issues commands and hosts the ALU.
interface alu_op_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_opcode;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic        cmd_use_acc;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_opcode;
   logic        alu_ena;
   logic [15:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic        rsp_dbz;

   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_acc, alu_result, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_opcode, alu_ena, rsp_valid, rsp_result, rsp_dbz
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_acc, alu_result, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_opcode, alu_ena, rsp_valid, rsp_result, rsp_dbz
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequencer in front of an 8-bit ALU: accepts one op, holds it for a per-class
// multicycle window, captures the 16-bit result and returns it with an accumulator.
module alu_op_sequencer #(
   parameter int unsigned MUL_WAIT = 1,
   parameter int unsigned DIV_WAIT = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   alu_op_sequencer_if.slave    bus,
   output logic [15:0]          acc,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] MUL_W = 3'(MUL_WAIT);
   localparam logic [2:0] DIV_W = 3'(DIV_WAIT);

   state_t     state_r;
   logic [2:0] cnt_r;

   function automatic logic is_div(input logic [2:0] op);
      return (op == 3'd3) || (op == 3'd4);
   endfunction

   function automatic logic [2:0] wait_for(input logic [2:0] op);
      logic [2:0] w;
      case (op)
         3'd2:    w = MUL_W;
         3'd3:    w = DIV_W;
         3'd4:    w = DIV_W;
         default: w = 3'd0;
      endcase
      return w;
   endfunction

   assign bus.cmd_ready = rst_n & ena & (state_r == IDLE);
   assign busy          = (state_r != IDLE);

   // Sequencer FSM; ALU pins are registered so they read zero outside EXEC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         cnt_r          <= 3'd0;
         bus.alu_a      <= 8'd0;
         bus.alu_b      <= 8'd0;
         bus.alu_opcode <= 3'd0;
         bus.alu_ena    <= 1'b0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_result <= 16'd0;
         bus.rsp_dbz    <= 1'b0;
         acc            <= 16'd0;
      end else if (ena) begin
         case (state_r)
            IDLE: begin
               if (bus.cmd_valid) begin
                  bus.alu_a      <= bus.cmd_use_acc ? acc[7:0] : bus.cmd_a;
                  bus.alu_b      <= bus.cmd_b;
                  bus.alu_opcode <= bus.cmd_opcode;
                  bus.alu_ena    <= 1'b1;
                  cnt_r          <= wait_for(bus.cmd_opcode);
                  state_r        <= EXEC;
               end
            end
            EXEC: begin
               if (cnt_r == 3'd0) begin
                  bus.rsp_result <= bus.alu_result;
                  bus.rsp_dbz    <= is_div(bus.alu_opcode) && (bus.alu_b == 8'd0);
                  // Compares (101..111) produce flags, not values worth chaining.
                  if (bus.alu_opcode <= 3'd4) begin
                     acc <= bus.alu_result;
                  end
                  bus.alu_a      <= 8'd0;
                  bus.alu_b      <= 8'd0;
                  bus.alu_opcode <= 3'd0;
                  bus.alu_ena    <= 1'b0;
                  bus.rsp_valid  <= 1'b1;
                  state_r        <= RESP;
               end else begin
                  cnt_r <= cnt_r - 3'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state_r       <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
